pat_gen_axis: RTL and testbench

Parametrised AXI4-Stream test-pattern source for the VLC light-modulator path. It drives the same `light_modu_*` stream the modulator consumes and emits framed bursts. Each frame is a length header word followed by payload words in a runtime-selectable pattern (counter, PRBS-31, constant, walking-one), with a programmable inter-frame gap. It replaces the fixed-length, counter-only generator and is fully AXI-compliant: data holds under backpressure, and `tvalid` never drops before a handshake.

---
 rtl/pat_gen_pkg.sv | 38 +++
 rtl/pat_gen_axis_prbs.sv | 67 ++++++
 rtl/pat_gen_axis.sv | 199 +++++++++++++++++++
 tb/tb_pat_gen_axis.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pat_gen_pkg.sv
// -----------------------------------------------------------------------------
// pat_gen_pkg
// Shared types and constants for the pat_gen_axis test-pattern source.
//   state_e  : frame sequencer states
//   mode_e   : payload pattern selector
//   PRBS_*   : PRBS-31 (x^31 + x^28 + 1) register width, taps and reset value
//   prbs_fix_seed : maps the forbidden all-zero LFSR seed onto 1
// -----------------------------------------------------------------------------
package pat_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_GAP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_CNT   = 2'd0,
        MODE_PRBS  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_WALK  = 2'd3
    } mode_e;

    // PRBS-31 register. Bit 30 is the oldest bit and is the next one shifted
    // out; the feedback bit (bit 30 xor bit 27, i.e. the x^31 and x^28 terms)
    // is shifted in at bit 0.
    localparam int               PRBS_W      = 31;
    localparam int               PRBS_TAP_HI = 30;
    localparam int               PRBS_TAP_LO = 27;
    localparam logic [PRBS_W-1:0] PRBS_RESET = 31'd1;

    // An all-zero LFSR never leaves zero, so a zero seed is replaced by 1.
    function automatic logic [PRBS_W-1:0] prbs_fix_seed(input logic [PRBS_W-1:0] seed);
        return (seed == '0) ? PRBS_RESET : seed;
    endfunction

endpackage

// File: rtl/pat_gen_axis_prbs.sv
// -----------------------------------------------------------------------------
// pat_prbs_word
// Parallel PRBS-31 word generator. The 31-bit LFSR state is registered; the
// DATA_W output bits for the current state and the state DATA_W shifts later
// are produced by a combinationally unrolled loop.
//   clk_i   : clock
//   arst_ni : asynchronous active-low reset (state returns to 1)
//   load_i  : load state from seed_i (zero seed becomes 1); wins over step_i
//   seed_i  : 31-bit seed
//   step_i  : advance the state by DATA_W bits
//   word_o  : next DATA_W output bits, first-generated bit in the MSB
// -----------------------------------------------------------------------------
module pat_prbs_word
    import pat_gen_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              arst_ni,
    input  logic              load_i,
    input  logic [PRBS_W-1:0] seed_i,
    input  logic              step_i,
    output logic [DATA_W-1:0] word_o
);

    logic [PRBS_W-1:0] state_q;
    logic [PRBS_W-1:0] state_d;
    logic [PRBS_W-1:0] walk_s;
    logic [PRBS_W-1:0] state_adv;
    logic [DATA_W-1:0] word_d;

    // NOTE: blocking assignments are required here because walk_s is a
    // scratch variable re-used by every unrolled iteration; each iteration
    // must see the value the previous one just wrote.
    always_comb begin
        walk_s = state_q;
        word_d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            word_d[DATA_W-1-i] = walk_s[PRBS_TAP_HI];
            walk_s = {walk_s[PRBS_W-2:0], walk_s[PRBS_TAP_HI] ^ walk_s[PRBS_TAP_LO]};
        end
        state_adv = walk_s;
    end

    // NOTE: state_d gets a value on every path (the final else holds the
    // state), so this block cannot infer a latch.
    always_comb begin
        if (load_i) begin
            state_d = prbs_fix_seed(seed_i);
        end else if (step_i) begin
            state_d = state_adv;
        end else begin
            state_d = state_q;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= PRBS_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    assign word_o = word_d;

endmodule

// File: rtl/pat_gen_axis.sv
// -----------------------------------------------------------------------------
// pat_gen_axis
// AXI4-Stream framed test-pattern source for the light-modulator stream.
// Each frame is a header word (frame length in bytes) followed by L-1 payload
// words in the selected pattern; frames are separated by a programmable gap.
//   light_modu_clk / arst_n : clock, asynchronous active-low reset
//   cfg_enable     : keep starting frames while high
//   cfg_mode       : 0 counter, 1 PRBS-31, 2 constant, 3 walking-one
//   cfg_frame_len  : words per frame incl. header (<2 treated as 2)
//   cfg_gap        : idle cycles after a frame (plus one fixed cycle)
//   cfg_seed       : PRBS seed (low 31 bits) or constant payload value
//   light_modu_t*  : AXI4-Stream master (tdata/tvalid/tlast out, tready in)
//   frame_cnt      : completed frames, wraps
//   busy           : high whenever the sequencer is not idle
// All outputs come straight from flops; tready only feeds next-state logic.
// -----------------------------------------------------------------------------
module pat_gen_axis
    import pat_gen_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              light_modu_clk,
    input  logic              arst_n,
    input  logic              cfg_enable,
    input  logic [1:0]        cfg_mode,
    input  logic [LEN_W-1:0]  cfg_frame_len,
    input  logic [LEN_W-1:0]  cfg_gap,
    input  logic [DATA_W-1:0] cfg_seed,
    output logic [DATA_W-1:0] light_modu_tdata,
    output logic              light_modu_tvalid,
    output logic              light_modu_tlast,
    input  logic              light_modu_tready,
    output logic [LEN_W-1:0]  frame_cnt,
    output logic              busy
);

    localparam int BYTES = DATA_W / 8;

    // Sequencer and output registers.
    state_e            state_q;
    logic [DATA_W-1:0] tdata_q;
    logic              tvalid_q;
    logic              tlast_q;
    logic [LEN_W-1:0]  frame_cnt_q;
    logic              busy_q;

    // Per-frame latched configuration and payload tracking.
    logic [LEN_W-1:0]  len_q;       // clamped frame length
    logic [LEN_W-1:0]  k_q;         // index of the next payload word to present
    logic [LEN_W-1:0]  gap_q;       // gap latched on the tlast handshake
    logic [LEN_W-1:0]  gap_cnt_q;
    mode_e             mode_q;
    logic [DATA_W-1:0] const_q;
    logic [DATA_W-1:0] walk_q;      // one-hot, rotated per word: 1 << (k mod DATA_W)

    // Combinational helpers.
    logic              hs;
    logic              start_frame;
    logic              produce;
    logic [LEN_W-1:0]  len_new;
    logic [DATA_W-1:0] hdr_word;
    logic [PRBS_W-1:0] seed_low;
    logic [DATA_W-1:0] prbs_word;
    logic [DATA_W-1:0] payload_d;
    logic              tlast_d;

    assign hs = tvalid_q & light_modu_tready;

    // A frame starts from idle, or straight out of the gap, while enabled.
    assign start_frame = cfg_enable &&
                         ((state_q == S_IDLE) ||
                          ((state_q == S_GAP) && (gap_cnt_q == gap_q)));

    // A new payload word is loaded when the header is taken, and when a
    // non-final payload word is taken.
    assign produce = hs && ((state_q == S_HDR) ||
                            ((state_q == S_DATA) && !tlast_q));

    assign len_new = (cfg_frame_len < LEN_W'(2)) ? LEN_W'(2) : cfg_frame_len;

    // Multiplying in DATA_W bits gives the required truncation for free.
    assign hdr_word = DATA_W'(len_new) * DATA_W'(BYTES);

    generate
        if (DATA_W >= PRBS_W) begin : g_seed_wide
            assign seed_low = cfg_seed[PRBS_W-1:0];
        end else begin : g_seed_narrow
            assign seed_low = {{(PRBS_W-DATA_W){1'b0}}, cfg_seed};
        end
    endgenerate

    // The LFSR reloads on every header entry so each frame repeats the same
    // sequence, and steps each time its current word is consumed.
    pat_prbs_word #(
        .DATA_W (DATA_W)
    ) u_prbs (
        .clk_i   (light_modu_clk),
        .arst_ni (arst_n),
        .load_i  (start_frame),
        .seed_i  (seed_low),
        .step_i  (produce && (mode_q == MODE_PRBS)),
        .word_o  (prbs_word)
    );

    always_comb begin
        payload_d = '0;
        case (mode_q)
            MODE_CNT:   payload_d = DATA_W'(k_q);
            MODE_PRBS:  payload_d = prbs_word;
            MODE_CONST: payload_d = const_q;
            MODE_WALK:  payload_d = walk_q;
            default:    payload_d = '0;
        endcase
    end

    assign tlast_d = (k_q == (len_q - LEN_W'(2)));

    always_ff @(posedge light_modu_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= S_IDLE;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            frame_cnt_q <= '0;
            busy_q      <= 1'b0;
            len_q       <= LEN_W'(2);
            k_q         <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            mode_q      <= MODE_CNT;
            const_q     <= '0;
            walk_q      <= DATA_W'(1);
        end else begin
            if (start_frame) begin
                state_q  <= S_HDR;
                busy_q   <= 1'b1;
                tvalid_q <= 1'b1;
                tlast_q  <= 1'b0;
                tdata_q  <= hdr_word;
                len_q    <= len_new;
                mode_q   <= mode_e'(cfg_mode);
                const_q  <= cfg_seed;
                k_q      <= '0;
                walk_q   <= DATA_W'(1);
            end else begin
                case (state_q)
                    S_IDLE: begin
                        busy_q <= 1'b0;
                    end
                    S_HDR: begin
                        if (hs) begin
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (hs && tlast_q) begin
                            state_q     <= S_GAP;
                            tvalid_q    <= 1'b0;
                            tlast_q     <= 1'b0;
                            tdata_q     <= '0;
                            frame_cnt_q <= frame_cnt_q + LEN_W'(1);
                            gap_q       <= cfg_gap;
                            gap_cnt_q   <= '0;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt_q == gap_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + LEN_W'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase

                // Present the next payload word on the same edge that
                // consumed the previous one.
                if (produce) begin
                    tdata_q <= payload_d;
                    tlast_q <= tlast_d;
                    k_q     <= k_q + LEN_W'(1);
                    walk_q  <= {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
                end
            end
        end
    end

    assign light_modu_tdata  = tdata_q;
    assign light_modu_tvalid = tvalid_q;
    assign light_modu_tlast  = tlast_q;
    assign frame_cnt         = frame_cnt_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_pat_gen_axis.sv
`timescale 1ns/1ps
// Scoreboard bench for pat_gen_axis: stimulus pushes expected words into a
// queue, a negedge monitor pops and compares on every handshake and checks
// that tdata/tlast/tvalid hold across stalls.
module tb_pat_gen_axis;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic              cfg_enable = 1'b0;
    logic [1:0]        cfg_mode = 2'd0;
    logic [LEN_W-1:0]  cfg_frame_len = '0;
    logic [LEN_W-1:0]  cfg_gap = '0;
    logic [DATA_W-1:0] cfg_seed = '0;
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready = 1'b1;
    logic [LEN_W-1:0]  frame_cnt;
    logic              busy;

    pat_gen_axis #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .light_modu_clk    (clk),
        .arst_n            (arst_n),
        .cfg_enable        (cfg_enable),
        .cfg_mode          (cfg_mode),
        .cfg_frame_len     (cfg_frame_len),
        .cfg_gap           (cfg_gap),
        .cfg_seed          (cfg_seed),
        .light_modu_tdata  (tdata),
        .light_modu_tvalid (tvalid),
        .light_modu_tlast  (tlast),
        .light_modu_tready (tready),
        .frame_cnt         (frame_cnt),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Counter-mode frame of length len (already >= 2): header len*4, then 0..len-2.
    task automatic push_cnt_frame(input int len);
        push(DATA_W'(len * 4), 1'b0);
        for (int k = 0; k <= len - 2; k++) begin
            push(DATA_W'(k), k == len - 2);
        end
    endtask

    // Cycle counter and tready driver (inputs change 1 ns after the edge).
    always @(posedge clk) begin
        cyc++;
        #1;
        tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: negedge sampling sees the values the next rising edge uses.
    logic              stall_pending = 1'b0;
    logic [DATA_W-1:0] held_data = '0;
    logic              held_last = 1'b0;
    logic              prev_valid = 1'b0;
    int                last_hs_edge = 0;
    int                first_valid_edge = 0;
    exp_t              mon_e;

    always @(negedge clk) begin
        if (!arst_n) begin
            stall_pending = 1'b0;
            prev_valid    = 1'b0;
        end else begin
            if (stall_pending) begin
                check("stall_valid", 64'(tvalid), 64'd1);
                check("stall_data", 64'(tdata), 64'(held_data));
                check("stall_last", 64'(tlast), 64'(held_last));
            end
            if (tvalid && !prev_valid) begin
                first_valid_edge = cyc;
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got data 0x%0h last %0b with empty scoreboard", tdata, tlast);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_data", 64'(tdata), 64'(mon_e.data));
                    check("word_last", 64'(tlast), 64'(mon_e.last));
                end
                if (tlast) begin
                    last_hs_edge = cyc + 1;
                end
            end
            stall_pending = tvalid && !tready;
            held_data     = tdata;
            held_last     = tlast;
            prev_valid    = tvalid;
        end
    end

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_tvalid", 64'(tvalid), 64'd0);
        check("idle_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_q_le(input int n, input int budget);
        int t;
        t = 0;
        while (exp_q.size() > n && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("queue_level", 64'(exp_q.size()), 64'(n));
    endtask

    // Enable from idle, keep enabled until the header of frame n is up, then
    // drop enable and let the block finish and go idle.
    task automatic run_frames(input int n, input logic [DATA_W-1:0] hdr);
        logic [LEN_W-1:0] base;
        int t;
        base = frame_cnt;
        t = 0;
        cfg_enable = 1'b1;
        @(posedge clk);
        #1;
        check("hdr_latency_valid", 64'(tvalid), 64'd1);
        check("hdr_latency_data", 64'(tdata), 64'(hdr));
        while (!((frame_cnt == base + LEN_W'(n - 1)) && tvalid) && t < 4000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 4000) begin
            checks++;
            failures++;
            $display("FAIL run_frames_timeout: got frame_cnt %0d expected %0d", frame_cnt, base + LEN_W'(n - 1));
        end
        cfg_enable = 1'b0;
        wait_idle(4000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #2;
        check("rst_tdata", 64'(tdata), 64'd0);
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: L=40, gap=10, counter mode; enable dropped and mode changed
        // during the second frame, which must still complete as a counter frame.
        cfg_frame_len = 16'd40;
        cfg_gap       = 16'd10;
        cfg_mode      = 2'd0;
        push_cnt_frame(40);
        push_cnt_frame(40);
        cfg_enable = 1'b1;
        @(posedge clk);
        #1;
        check("t1_hdr_valid", 64'(tvalid), 64'd1);
        check("t1_hdr_data", 64'(tdata), 64'd160);
        wait_q_le(39, 200);
        check("t1_gap_delay", 64'(first_valid_edge - last_hs_edge), 64'd11);
        check("t1_frame_cnt_1", 64'(frame_cnt), 64'd1);
        cfg_enable    = 1'b0;
        cfg_mode      = 2'd3;
        cfg_frame_len = 16'd5;
        wait_idle(300);
        check("t1_frame_cnt_2", 64'(frame_cnt), 64'd2);
        repeat (5) @(posedge clk);
        #1;
        check("t1_stays_idle_valid", 64'(tvalid), 64'd0);
        check("t1_stays_idle_busy", 64'(busy), 64'd0);

        // Test 2: random backpressure, L=8, gap=0: header 32 then 0..6.
        cfg_mode      = 2'd0;
        cfg_frame_len = 16'd8;
        cfg_gap       = 16'd0;
        rand_ready    = 1'b1;
        push_cnt_frame(8);
        run_frames(1, 32'd32);
        rand_ready = 1'b0;
        check("t2_frame_cnt", 64'(frame_cnt), 64'd3);

        // Test 3: PRBS-31, seed 1, L=4, two identical frames. Hand-derived
        // words for the bit stream b[n+31] = b[n] ^ b[n+3], b[0..30] = seed
        // MSB first: 0x00000002, 0x00000024, 0x00000208.
        cfg_mode      = 2'd1;
        cfg_seed      = 32'd1;
        cfg_frame_len = 16'd4;
        cfg_gap       = 16'd2;
        for (int f = 0; f < 2; f++) begin
            push(32'd16, 1'b0);
            push(32'h0000_0002, 1'b0);
            push(32'h0000_0024, 1'b0);
            push(32'h0000_0208, 1'b1);
        end
        run_frames(2, 32'd16);
        // Seed 0 must behave exactly like seed 1.
        cfg_seed = 32'd0;
        push(32'd16, 1'b0);
        push(32'h0000_0002, 1'b0);
        push(32'h0000_0024, 1'b0);
        push(32'h0000_0208, 1'b1);
        run_frames(1, 32'd16);

        // Test 4: frame lengths 0 and 1 are treated as 2.
        cfg_mode = 2'd0;
        for (int l = 0; l < 2; l++) begin
            cfg_frame_len = LEN_W'(l);
            push(32'd8, 1'b0);
            push(32'd0, 1'b1);
            run_frames(1, 32'd8);
        end

        // Test 5: constant mode, then walking-one across the DATA_W wrap.
        cfg_mode      = 2'd2;
        cfg_seed      = 32'hA5A5_0F0F;
        cfg_frame_len = 16'd3;
        push(32'd12, 1'b0);
        push(32'hA5A5_0F0F, 1'b0);
        push(32'hA5A5_0F0F, 1'b1);
        run_frames(1, 32'd12);
        cfg_mode      = 2'd3;
        cfg_frame_len = 16'd34;
        push(32'd136, 1'b0);
        for (int k = 0; k <= 32; k++) begin
            push(32'd1 << (k % 32), k == 32);
        end
        run_frames(1, 32'd136);
        check("t5_frame_cnt", 64'(frame_cnt), 64'd10);

        // Test 6: reset during S_DATA clears outputs immediately, then a fresh
        // frame starts from a header with frame_cnt back at 0.
        cfg_mode      = 2'd0;
        cfg_frame_len = 16'd40;
        cfg_gap       = 16'd3;
        push_cnt_frame(40);
        cfg_enable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("t6_pre_reset_busy", 64'(busy), 64'd1);
        arst_n = 1'b0;
        #1;
        check("t6_rst_tdata", 64'(tdata), 64'd0);
        check("t6_rst_tvalid", 64'(tvalid), 64'd0);
        check("t6_rst_tlast", 64'(tlast), 64'd0);
        check("t6_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        cfg_enable = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        check("t6_post_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        push_cnt_frame(40);
        run_frames(1, 32'd160);
        check("t6_frame_cnt", 64'(frame_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
